// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between instruction fetch
// and the data load/store path. One transaction is in flight at a time; ties are
// broken by alternating against the last grant, and a watchdog aborts
// transactions the bus never acknowledges.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   if_req/if_addr                   fetch request and address
//   if_rdata/if_ack/if_err           fetch response (one-cycle ack/err pulse)
//   d_req/d_we/d_be/d_addr/d_wdata   data request and payload
//   d_rdata/d_ack/d_err              data response (one-cycle ack/err pulse)
//   bus_req/bus_we/bus_be/bus_addr/bus_wdata  registered bus request
//   bus_rdata/bus_ack                bus response
module mem_port_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ack,
  output logic            if_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [3:0]      d_be,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_ack,
  output logic            d_err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_ack
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  // owner / last_grant encoding: 0 = fetch, 1 = data
  state_t          state, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            grant_data;

  logic            bus_req_d, bus_we_d;
  logic [3:0]      bus_be_d;
  logic [XLEN-1:0] bus_addr_d, bus_wdata_d;
  logic            if_ack_d, if_err_d, d_ack_d, d_err_d;
  logic [XLEN-1:0] if_rdata_d, d_rdata_d;

  // State and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= 4'h0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      bus_req   <= bus_req_d;
      bus_we    <= bus_we_d;
      bus_be    <= bus_be_d;
      bus_addr  <= bus_addr_d;
      bus_wdata <= bus_wdata_d;
      if_ack    <= if_ack_d;
      if_err    <= if_err_d;
      d_ack     <= d_ack_d;
      d_err     <= d_err_d;
      if_rdata  <= if_rdata_d;
      d_rdata   <= d_rdata_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    grant_data  = 1'b0;
    bus_req_d   = bus_req;
    bus_we_d    = bus_we;
    bus_be_d    = bus_be;
    bus_addr_d  = bus_addr;
    bus_wdata_d = bus_wdata;
    if_ack_d    = 1'b0;
    if_err_d    = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;

    unique case (state)
      S_IDLE: begin
        if (if_req || d_req) begin
          // Data wins when alone, or on a tie if fetch was granted last
          grant_data = d_req && (!if_req || !last_q);
          owner_d    = grant_data;
          last_d     = grant_data;
          cnt_d      = '0;
          bus_req_d  = 1'b1;
          if (grant_data) begin
            bus_we_d    = d_we;
            bus_be_d    = d_be;
            bus_addr_d  = d_addr;
            bus_wdata_d = d_wdata;
          end else begin
            bus_we_d    = 1'b0;
            bus_be_d    = 4'hF;
            bus_addr_d  = if_addr;
            bus_wdata_d = '0;
          end
          state_d = S_BUS;
        end
      end

      S_BUS: begin
        if (bus_ack) begin
          // An ack on the final watchdog cycle still completes as OK
          bus_req_d = 1'b0;
          state_d   = S_RESP;
          if (owner_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = bus_we ? '0 : bus_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus_rdata;
          end
        end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
          // This edge is the TIMEOUT-th bus cycle without an ack
          bus_req_d = 1'b0;
          state_d   = S_RESP;
          if (owner_q) begin
            d_err_d   = 1'b1;
            d_rdata_d = '0;
          end else begin
            if_err_d   = 1'b1;
            if_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 4-cycle watchdog.
module tb_mem_port_arbiter;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic [XLEN-1:0] if_rdata;
  logic            if_ack, if_err;
  logic            d_req, d_we;
  logic [3:0]      d_be;
  logic [XLEN-1:0] d_addr, d_wdata, d_rdata;
  logic            d_ack, d_err;
  logic            bus_req, bus_we;
  logic [3:0]      bus_be;
  logic [XLEN-1:0] bus_addr, bus_wdata, bus_rdata;
  logic            bus_ack;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ack(if_ack), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response flags packed as {if_ack, if_err, d_ack, d_err}
  function automatic logic [31:0] flags();
    return 32'({if_ack, if_err, d_ack, d_err});
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, flags(), 0);
    chk({tag, "_bus_req"}, 32'(bus_req), 0);
    chk({tag, "_bus_we"}, 32'(bus_we), 0);
    chk({tag, "_bus_be"}, 32'(bus_be), 0);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_bus_wdata"}, bus_wdata, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Fetch with a 2-cycle bus
    if_req = 1'b1; if_addr = 32'h100;
    step();
    chk("f_bus_req", 32'(bus_req), 1);
    chk("f_bus_be", 32'(bus_be), 32'hF);
    chk("f_bus_we", 32'(bus_we), 0);
    chk("f_bus_addr", bus_addr, 32'h100);
    step();
    chk("f_wait_req", 32'(bus_req), 1);
    chk("f_wait_flags", flags(), 0);
    bus_ack = 1'b1; bus_rdata = 32'h0000_0013;
    step();
    chk("f_ack_flags", flags(), 4'b1000);
    chk("f_rdata", if_rdata, 32'h0000_0013);
    chk("f_resp_bus_req", 32'(bus_req), 0);
    bus_ack = 1'b0; if_req = 1'b0;
    step();
    chk("f_idle_flags", flags(), 0);
    step();
    chk("f_idle_bus_req", 32'(bus_req), 0);

    // Both requesters saturated: data, fetch, data, fetch
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h400;
    step();
    chk("arb1_addr", bus_addr, 32'h400);
    bus_ack = 1'b1; bus_rdata = 32'hA1;
    step();
    chk("arb1_flags", flags(), 4'b0010);
    chk("arb1_rdata", d_rdata, 32'hA1);
    bus_ack = 1'b0;
    step(); step();
    chk("arb2_addr", bus_addr, 32'h300);
    chk("arb2_be", 32'(bus_be), 32'hF);
    bus_ack = 1'b1; bus_rdata = 32'hB2;
    step();
    chk("arb2_flags", flags(), 4'b1000);
    chk("arb2_rdata", if_rdata, 32'hB2);
    bus_ack = 1'b0;
    step(); step();
    chk("arb3_addr", bus_addr, 32'h400);
    bus_ack = 1'b1; bus_rdata = 32'hC3;
    step();
    chk("arb3_flags", flags(), 4'b0010);
    chk("arb3_rdata", d_rdata, 32'hC3);
    bus_ack = 1'b0; d_req = 1'b0;
    step(); step();
    chk("arb4_addr", bus_addr, 32'h300);
    bus_ack = 1'b1; bus_rdata = 32'hD4;
    step();
    chk("arb4_flags", flags(), 4'b1000);
    chk("arb4_rdata", if_rdata, 32'hD4);
    chk("arb4_d_rdata_kept", d_rdata, 32'hC3);
    bus_ack = 1'b0; if_req = 1'b0;
    step(); step();
    chk("arb_no_dup", 32'(bus_req), 0);

    // Zero-wait store: 3-cycle occupancy, d_rdata forced to 0
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    step();
    chk("st_bus_req", 32'(bus_req), 1);
    chk("st_bus_we", 32'(bus_we), 1);
    chk("st_bus_be", 32'(bus_be), 32'h3);
    chk("st_bus_addr", bus_addr, 32'h2000);
    chk("st_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
    step();
    chk("st_flags", flags(), 4'b0010);
    chk("st_rdata", d_rdata, 0);
    chk("st_resp_bus_req", 32'(bus_req), 0);
    bus_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
    step();
    chk("st_done_flags", flags(), 0);

    // Watchdog: bus_req high for 4 cycles, then d_err; pending fetch next
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    step();
    chk("to_req1", 32'(bus_req), 1);
    step();
    chk("to_req2", 32'(bus_req), 1);
    if_req = 1'b1; if_addr = 32'h600;
    step();
    chk("to_req3", 32'(bus_req), 1);
    step();
    chk("to_req4", 32'(bus_req), 1);
    chk("to_req4_flags", flags(), 0);
    step();
    chk("to_req_dropped", 32'(bus_req), 0);
    chk("to_err_flags", flags(), 4'b0001);
    d_req = 1'b0;
    step();
    chk("to_after_flags", flags(), 0);
    step();
    chk("to_next_fetch_req", 32'(bus_req), 1);
    chk("to_next_fetch_addr", bus_addr, 32'h600);
    bus_ack = 1'b1; bus_rdata = 32'h11;
    step();
    chk("to_fetch_flags", flags(), 4'b1000);
    chk("to_fetch_rdata", if_rdata, 32'h11);
    bus_ack = 1'b0; if_req = 1'b0;
    step();

    // Reset during the 2nd bus cycle of a fetch
    if_req = 1'b1; if_addr = 32'h800;
    step();
    step();
    chk("rst_mid_req", 32'(bus_req), 1);
    rst = 1'b1;
    step();
    chk_all_zero("rst_mid");
    rst = 1'b0; if_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h77;
    step();
    chk("rst_late_ack_flags", flags(), 0);
    chk("rst_late_ack_req", 32'(bus_req), 0);
    chk("rst_late_ack_rdata", if_rdata, 0);

    // Spurious ack while IDLE
    step();
    chk("spur_flags", flags(), 0);
    chk("spur_bus_req", 32'(bus_req), 0);
    bus_ack = 1'b0;

    // Payload changes during BUS are ignored
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hC; d_addr = 32'h900; d_wdata = 32'h1234_5678;
    step();
    d_we = 1'b0; d_be = 4'hF; d_addr = 32'hAAA; d_wdata = 32'h0;
    step();
    chk("hold_addr", bus_addr, 32'h900);
    chk("hold_wdata", bus_wdata, 32'h1234_5678);
    chk("hold_be", 32'(bus_be), 32'hC);
    chk("hold_we", 32'(bus_we), 1);
    chk("hold_flags", flags(), 0);
    bus_ack = 1'b1; bus_rdata = 32'h99;
    step();
    chk("hold_ack_flags", flags(), 4'b0010);
    chk("hold_ack_rdata", d_rdata, 0);
    bus_ack = 1'b0; d_req = 1'b0;
    step();
    chk("hold_end_flags", flags(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
